// File: rtl/reservation_station_pkg.sv
// Shared types and constants for the reservation station slice.
//  - op_e       : ALU operation encoding, OP_NOP means "nothing issued"
//  - rob_pos_t  : ROB tag, ZERO_ROB means "no producer / value present"
//  - data_t     : operand / immediate word
//  - addr_t     : instruction address
//  - operand_t  : one source operand (producer tag + value)
//  - capture_operand : resolves an operand against the ALU and LSB result buses
package reservation_station_pkg;

   localparam int RS_SIZE_DEF  = 16;
   localparam int RS_IDX_W_DEF = 4;
   localparam int ROB_POS_W    = 5;
   localparam int DATA_W       = 32;
   localparam int ADDR_W       = 32;

   typedef logic [ROB_POS_W-1:0] rob_pos_t;
   typedef logic [DATA_W-1:0]    data_t;
   typedef logic [ADDR_W-1:0]    addr_t;

   localparam rob_pos_t ZERO_ROB  = '0;
   localparam data_t    ZERO_WORD = '0;

   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,
      OP_ADD  = 4'd1,
      OP_SUB  = 4'd2,
      OP_AND  = 4'd3,
      OP_OR   = 4'd4,
      OP_XOR  = 4'd5,
      OP_SLL  = 4'd6,
      OP_SRL  = 4'd7,
      OP_SRA  = 4'd8,
      OP_SLT  = 4'd9,
      OP_SLTU = 4'd10
   } op_e;

   typedef struct packed {
      rob_pos_t q;
      data_t    v;
   } operand_t;

   // An operand still waiting on a producer picks up the value of a matching
   // broadcast. The ALU bus wins if both match; the two buses never carry the
   // same tag in one cycle, so the order only matters for determinism.
   function automatic operand_t capture_operand(
      input operand_t cur,
      input rob_pos_t alu_tag,
      input data_t    alu_value,
      input rob_pos_t lsb_tag,
      input data_t    lsb_value
   );
      operand_t res;
      res = cur;
      if (cur.q != ZERO_ROB) begin
         if (cur.q == alu_tag) begin
            res.q = ZERO_ROB;
            res.v = alu_value;
         end else if (cur.q == lsb_tag) begin
            res.q = ZERO_ROB;
            res.v = lsb_value;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/reservation_station_find_first.sv
// Lowest-set-bit encoder.
//  vec   in  WIDTH   request vector
//  idx   out IDX_W   index of the lowest set bit (0 when none set)
//  found out 1       at least one bit of vec is set
module reservation_station_find_first #(
   parameter int WIDTH = 16,
   parameter int IDX_W = 4
) (
   input  logic [WIDTH-1:0] vec,
   output logic [IDX_W-1:0] idx,
   output logic             found
);

   // Scan from the top down so the last hit (the lowest index) wins.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx   = IDX_W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reservation_station.sv
// Reservation station for ALU-class ops: buffers dispatched ops until both
// operands are known (waking them from the ALU/LSB result buses) and issues
// at most one ready op per cycle to the ALU through registered outputs.
//  clk, rst (sync, active-low), rdy (global enable), in_flush
//  in_dispatch_en, in_op, in_q1/in_q2, in_v1/in_v2, in_imm, in_pc, in_rob_tag : dispatch
//  out_full                                   : no free entry (combinational)
//  in_alu_tag/in_alu_value, in_lsb_tag/in_lsb_value : result broadcasts
//  out_op, out_value1, out_value2, out_imm, out_pc, out_rob_tag : ALU issue
module reservation_station
   import reservation_station_pkg::*;
#(
   parameter int RS_SIZE  = RS_SIZE_DEF,
   parameter int RS_IDX_W = RS_IDX_W_DEF
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     rdy,
   input  logic     in_flush,
   input  logic     in_dispatch_en,
   input  op_e      in_op,
   input  rob_pos_t in_q1,
   input  rob_pos_t in_q2,
   input  data_t    in_v1,
   input  data_t    in_v2,
   input  data_t    in_imm,
   input  addr_t    in_pc,
   input  rob_pos_t in_rob_tag,
   output logic     out_full,
   input  rob_pos_t in_alu_tag,
   input  data_t    in_alu_value,
   input  rob_pos_t in_lsb_tag,
   input  data_t    in_lsb_value,
   output op_e      out_op,
   output data_t    out_value1,
   output data_t    out_value2,
   output data_t    out_imm,
   output addr_t    out_pc,
   output rob_pos_t out_rob_tag
);

   logic [RS_SIZE-1:0] valid_reg;
   op_e                op_reg    [RS_SIZE];
   operand_t           opnd1_reg [RS_SIZE];
   operand_t           opnd2_reg [RS_SIZE];
   data_t              imm_reg   [RS_SIZE];
   addr_t              pc_reg    [RS_SIZE];
   rob_pos_t           tag_reg   [RS_SIZE];

   logic [RS_SIZE-1:0]  ready_vec;
   logic [RS_IDX_W-1:0] free_idx;
   logic [RS_IDX_W-1:0] ready_idx;
   logic                free_found;
   logic                ready_found;

   // Readiness is judged on start-of-cycle state: an operand woken on this
   // edge only becomes eligible for issue on the next one.
   generate
      for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_ready
         assign ready_vec[gi] = valid_reg[gi]
                             && (opnd1_reg[gi].q == ZERO_ROB)
                             && (opnd2_reg[gi].q == ZERO_ROB);
      end
   endgenerate

   assign out_full = &valid_reg;

   reservation_station_find_first #(
      .WIDTH (RS_SIZE),
      .IDX_W (RS_IDX_W)
   ) u_free_find (
      .vec   (~valid_reg),
      .idx   (free_idx),
      .found (free_found)
   );

   reservation_station_find_first #(
      .WIDTH (RS_SIZE),
      .IDX_W (RS_IDX_W)
   ) u_ready_find (
      .vec   (ready_vec),
      .idx   (ready_idx),
      .found (ready_found)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_reg   <= '0;
         out_op      <= OP_NOP;
         out_value1  <= ZERO_WORD;
         out_value2  <= ZERO_WORD;
         out_imm     <= ZERO_WORD;
         out_pc      <= '0;
         out_rob_tag <= ZERO_ROB;
      end else if (rdy) begin
         if (in_flush) begin
            valid_reg   <= '0;
            out_op      <= OP_NOP;
            out_rob_tag <= ZERO_ROB;
         end else begin
            // Wakeup of waiting operands in every live entry.
            for (int i = 0; i < RS_SIZE; i++) begin
               if (valid_reg[i]) begin
                  opnd1_reg[i] <= capture_operand(opnd1_reg[i], in_alu_tag, in_alu_value,
                                                  in_lsb_tag, in_lsb_value);
                  opnd2_reg[i] <= capture_operand(opnd2_reg[i], in_alu_tag, in_alu_value,
                                                  in_lsb_tag, in_lsb_value);
               end
            end

            // Issue: the selected entry leaves on this edge. Its slot stays
            // unusable for dispatch until next cycle because free_idx was
            // computed from the start-of-cycle valid bits.
            if (ready_found) begin
               out_op                <= op_reg[ready_idx];
               out_value1            <= opnd1_reg[ready_idx].v;
               out_value2            <= opnd2_reg[ready_idx].v;
               out_imm               <= imm_reg[ready_idx];
               out_pc                <= pc_reg[ready_idx];
               out_rob_tag           <= tag_reg[ready_idx];
               valid_reg[ready_idx]  <= 1'b0;
            end else begin
               out_op      <= OP_NOP;
               out_rob_tag <= ZERO_ROB;
            end

            // Dispatch into the lowest free slot; that slot is invalid, so it
            // never collides with the wakeup loop or the issued entry.
            if (in_dispatch_en && free_found) begin
               valid_reg[free_idx] <= 1'b1;
               op_reg[free_idx]    <= in_op;
               opnd1_reg[free_idx] <= capture_operand('{q: in_q1, v: in_v1}, in_alu_tag,
                                                      in_alu_value, in_lsb_tag, in_lsb_value);
               opnd2_reg[free_idx] <= capture_operand('{q: in_q2, v: in_v2}, in_alu_tag,
                                                      in_alu_value, in_lsb_tag, in_lsb_value);
               imm_reg[free_idx]   <= in_imm;
               pc_reg[free_idx]    <= in_pc;
               tag_reg[free_idx]   <= in_rob_tag;
            end
         end
      end
   end

endmodule

// File: tb/tb_reservation_station.sv
// Directed testbench for reservation_station with a scoreboard: stimulus
// pushes expected issues (including the cycle they must appear in) and a
// negedge monitor pops and compares every issue the DUT presents.
module tb_reservation_station;
   import reservation_station_pkg::*;

   logic     clk = 1'b0;
   logic     rst;
   logic     rdy;
   logic     in_flush;
   logic     in_dispatch_en;
   op_e      in_op;
   rob_pos_t in_q1, in_q2, in_rob_tag, in_alu_tag, in_lsb_tag;
   data_t    in_v1, in_v2, in_imm, in_alu_value, in_lsb_value;
   addr_t    in_pc;
   logic     out_full;
   op_e      out_op;
   data_t    out_value1, out_value2, out_imm;
   addr_t    out_pc;
   rob_pos_t out_rob_tag;

   reservation_station dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .in_flush       (in_flush),
      .in_dispatch_en (in_dispatch_en),
      .in_op          (in_op),
      .in_q1          (in_q1),
      .in_q2          (in_q2),
      .in_v1          (in_v1),
      .in_v2          (in_v2),
      .in_imm         (in_imm),
      .in_pc          (in_pc),
      .in_rob_tag     (in_rob_tag),
      .out_full       (out_full),
      .in_alu_tag     (in_alu_tag),
      .in_alu_value   (in_alu_value),
      .in_lsb_tag     (in_lsb_tag),
      .in_lsb_value   (in_lsb_value),
      .out_op         (out_op),
      .out_value1     (out_value1),
      .out_value2     (out_value2),
      .out_imm        (out_imm),
      .out_pc         (out_pc),
      .out_rob_tag    (out_rob_tag)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;

   typedef struct {
      op_e      op;
      data_t    v1;
      data_t    v2;
      data_t    imm;
      addr_t    pc;
      rob_pos_t tag;
      int       cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every non-NOP output must match the oldest expected issue.
   always @(negedge clk) begin
      if (mon_en) begin
         if (out_op != OP_NOP) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_issue: got op %s tag %0d, expected none (cycle %0d)",
                        out_op.name(), out_rob_tag, cyc);
            end else begin
               mon_e = exp_q.pop_front();
               $display("issue: cycle %0d op %s tag %0d v1 0x%0h v2 0x%0h imm 0x%0h pc 0x%0h",
                        cyc, out_op.name(), out_rob_tag, out_value1, out_value2, out_imm, out_pc);
               chk("issue_cycle", 64'(cyc), 64'(mon_e.cyc));
               chk("issue_op", 64'(out_op), 64'(mon_e.op));
               chk("issue_value1", 64'(out_value1), 64'(mon_e.v1));
               chk("issue_value2", 64'(out_value2), 64'(mon_e.v2));
               chk("issue_imm", 64'(out_imm), 64'(mon_e.imm));
               chk("issue_pc", 64'(out_pc), 64'(mon_e.pc));
               chk("issue_rob_tag", 64'(out_rob_tag), 64'(mon_e.tag));
            end
         end else begin
            chk("idle_rob_tag", 64'(out_rob_tag), 64'(ZERO_ROB));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clear_inputs();
      in_flush       = 1'b0;
      in_dispatch_en = 1'b0;
      in_op          = OP_NOP;
      in_q1          = ZERO_ROB;
      in_q2          = ZERO_ROB;
      in_v1          = ZERO_WORD;
      in_v2          = ZERO_WORD;
      in_imm         = ZERO_WORD;
      in_pc          = '0;
      in_rob_tag     = ZERO_ROB;
      in_alu_tag     = ZERO_ROB;
      in_alu_value   = ZERO_WORD;
      in_lsb_tag     = ZERO_ROB;
      in_lsb_value   = ZERO_WORD;
   endtask

   task automatic expect_issue(input op_e op, input data_t v1, input data_t v2, input data_t imm,
                               input addr_t pc, input rob_pos_t tag, input int at_cyc);
      exp_t e;
      e.op  = op;
      e.v1  = v1;
      e.v2  = v2;
      e.imm = imm;
      e.pc  = pc;
      e.tag = tag;
      e.cyc = at_cyc;
      exp_q.push_back(e);
   endtask

   // Presents one dispatch for one edge; broadcasts set by the caller stay as they are.
   task automatic send(input op_e op, input rob_pos_t q1, input data_t v1, input rob_pos_t q2,
                       input data_t v2, input data_t imm, input addr_t pc, input rob_pos_t tag);
      in_dispatch_en = 1'b1;
      in_op          = op;
      in_q1          = q1;
      in_v1          = v1;
      in_q2          = q2;
      in_v2          = v2;
      in_imm         = imm;
      in_pc          = pc;
      in_rob_tag     = tag;
      step();
      in_dispatch_en = 1'b0;
      in_op          = OP_NOP;
   endtask

   initial begin
      int c;
      clear_inputs();
      rst = 1'b0;
      rdy = 1'b1;

      // Reset held for two edges, then released.
      idle(2);
      rst = 1'b1;
      step();
      chk("reset_out_op", 64'(out_op), 64'(OP_NOP));
      chk("reset_rob_tag", 64'(out_rob_tag), 64'(ZERO_ROB));
      chk("reset_full", 64'(out_full), 64'd0);
      chk("reset_value1", 64'(out_value1), 64'd0);
      mon_en = 1'b1;

      // Operand-ready dispatch issues after the next edge.
      c = cyc;
      expect_issue(OP_ADD, 32'd5, 32'd7, 32'd0, 32'h100, 5'd3, c + 2);
      send(OP_ADD, ZERO_ROB, 32'd5, ZERO_ROB, 32'd7, 32'd0, 32'h100, 5'd3);
      idle(3);

      // Wait on tag 4, woken three cycles later by the ALU bus.
      send(OP_SUB, 5'd4, 32'd0, ZERO_ROB, 32'd9, 32'd1, 32'h104, 5'd6);
      idle(2);
      c = cyc;
      in_alu_tag   = 5'd4;
      in_alu_value = 32'd20;
      expect_issue(OP_SUB, 32'd20, 32'd9, 32'd1, 32'h104, 5'd6, c + 2);
      step();
      clear_inputs();
      idle(3);

      // Same op, forwarded from the LSB bus in the dispatch cycle.
      c = cyc;
      in_lsb_tag   = 5'd4;
      in_lsb_value = 32'd33;
      expect_issue(OP_SUB, 32'd33, 32'd9, 32'd1, 32'h108, 5'd7, c + 2);
      send(OP_SUB, 5'd4, 32'd0, ZERO_ROB, 32'd9, 32'd1, 32'h108, 5'd7);
      clear_inputs();
      idle(3);

      // Both operands woken together, one from each bus.
      send(OP_AND, 5'd11, 32'd0, 5'd12, 32'd0, 32'd2, 32'h10c, 5'd8);
      c = cyc;
      in_alu_tag   = 5'd11;
      in_alu_value = 32'hAA;
      in_lsb_tag   = 5'd12;
      in_lsb_value = 32'hBB;
      expect_issue(OP_AND, 32'hAA, 32'hBB, 32'd2, 32'h10c, 5'd8, c + 2);
      step();
      clear_inputs();
      idle(3);

      // Both operands forwarded at dispatch, one from each bus.
      c = cyc;
      in_alu_tag   = 5'd13;
      in_alu_value = 32'h111;
      in_lsb_tag   = 5'd14;
      in_lsb_value = 32'h222;
      expect_issue(OP_SLL, 32'h111, 32'h222, 32'd3, 32'h110, 5'd9, c + 2);
      send(OP_SLL, 5'd13, 32'd0, 5'd14, 32'd0, 32'd3, 32'h110, 5'd9);
      clear_inputs();
      idle(3);

      // Fill all 16 entries waiting on tag 2; a 17th dispatch is dropped.
      for (int i = 0; i < 16; i++) begin
         send(OP_OR, 5'd2, 32'd0, ZERO_ROB, 32'(i * 3 + 1), 32'(i), 32'(32'h200 + 4 * i),
              rob_pos_t'(i + 1));
      end
      chk("full_after_16", 64'(out_full), 64'd1);
      send(OP_XOR, 5'd2, 32'd0, ZERO_ROB, 32'hDEAD, 32'd0, 32'h300, 5'd20);
      chk("full_after_17th", 64'(out_full), 64'd1);
      idle(2);
      c = cyc;
      in_alu_tag   = 5'd2;
      in_alu_value = 32'h55;
      for (int i = 0; i < 16; i++) begin
         expect_issue(OP_OR, 32'h55, 32'(i * 3 + 1), 32'(i), 32'(32'h200 + 4 * i),
                      rob_pos_t'(i + 1), c + 2 + i);
      end
      step();
      clear_inputs();
      chk("full_after_wakeup", 64'(out_full), 64'd1);
      step();
      chk("full_after_first_issue", 64'(out_full), 64'd0);
      idle(18);

      // Flush with five waiting entries and a concurrent dispatch.
      for (int i = 0; i < 5; i++) begin
         send(OP_ADD, 5'd10, 32'd0, ZERO_ROB, 32'd1, 32'd0, 32'(32'h500 + 4 * i),
              rob_pos_t'(21 + i));
      end
      in_flush = 1'b1;
      send(OP_ADD, ZERO_ROB, 32'd4, ZERO_ROB, 32'd4, 32'd0, 32'h520, 5'd26);
      in_flush = 1'b0;
      chk("flush_out_op", 64'(out_op), 64'(OP_NOP));
      chk("flush_full", 64'(out_full), 64'd0);
      idle(3);
      in_alu_tag   = 5'd10;
      in_alu_value = 32'h10;
      step();
      clear_inputs();
      idle(3);
      c = cyc;
      expect_issue(OP_ADD, 32'd1, 32'd2, 32'd0, 32'h530, 5'd27, c + 2);
      send(OP_ADD, ZERO_ROB, 32'd1, ZERO_ROB, 32'd2, 32'd0, 32'h530, 5'd27);
      idle(3);

      // Freeze with a ready entry present and broadcasts toggling.
      send(OP_SLT, 5'd9, 32'd0, ZERO_ROB, 32'd5, 32'd0, 32'h400, 5'd28);
      send(OP_XOR, ZERO_ROB, 32'h0F, ZERO_ROB, 32'hF0, 32'd0, 32'h404, 5'd29);
      rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         clear_inputs();
         if (k == 1) begin
            in_lsb_tag   = 5'd9;
            in_lsb_value = 32'h99;
         end else begin
            in_alu_tag   = 5'd9;
            in_alu_value = 32'h99;
         end
         step();
         chk("frozen_out_op", 64'(out_op), 64'(OP_NOP));
         chk("frozen_value1", 64'(out_value1), 64'd1);
         chk("frozen_value2", 64'(out_value2), 64'd2);
      end
      clear_inputs();
      rdy = 1'b1;
      expect_issue(OP_XOR, 32'h0F, 32'hF0, 32'd0, 32'h404, 5'd29, cyc + 1);
      idle(4);
      c = cyc;
      in_alu_tag   = 5'd9;
      in_alu_value = 32'h77;
      expect_issue(OP_SLT, 32'h77, 32'd5, 32'd0, 32'h400, 5'd28, c + 2);
      step();
      clear_inputs();
      idle(4);

      // Anything still queued never appeared on the issue port.
      while (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         n_checks++;
         n_fail++;
         $display("FAIL missing_issue: got nothing, expected op %s tag %0d at cycle %0d",
                  mon_e.op.name(), mon_e.tag, mon_e.cyc);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
